serial_shift_engine: RTL and testbench
======================================

Name: serial_shift_engine

Overview:
- Downstream consumer of the serial clock generator's `sclk`/`sclk_edge` outputs.
- Accepts a parallel word over a valid/ready handshake and frames it with an active-low chip select.
- Shifts the word out MSB-first, one bit per `sclk_edge` pulse, and samples `miso` on the same pulses.
- Returns the received word to the host with a one-cycle `rx_valid` pulse. Sits between the host logic and the off-chip serial pins.

Parameters:
- WIDTH, 8, data bits per frame (≥2).
- CNT_W, 4, bit counter width; must satisfy 2**CNT_W > WIDTH+1.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sclk_edge  input  1  one-clk-wide pulse per serial bit period, from the clock generator.
- tx_data  input  WIDTH  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.
- cs_n  output  1  frame select, low for the whole frame.
- rx_data  output  WIDTH  last received word; held until the next frame completes.
- rx_valid  output  1  one-clk pulse; rx_data updated in the same cycle.
- rx_parity_err  output  1  parity mismatch flag, valid with rx_valid.
- busy  output  1  high from accept through the DONE cycle.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; tx_ready=1; cs_n=1; mosi=0; rx_data=0; rx_valid=0; rx_parity_err=0; busy=0; shift regs and counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - tx_ready=1, cs_n=1, mosi=0.
  - Accept when tx_valid & tx_ready at posedge: load tx shift reg ← tx_data, bit_cnt ← 0, go SHIFT.
  - Next cycle: tx_ready=0, busy=1, cs_n=0, mosi=tx_data[WIDTH-1].
- SHIFT:
  - mosi always equals the tx shift reg MSB.
  - Each sclk_edge: rx shift reg ← {rx_sr[WIDTH-2:0], miso}; tx shift reg ← shift left by 1 (zero fill); bit_cnt += 1.
  - When the edge makes bit_cnt == FRAME (FRAME=WIDTH, or WIDTH+1 with the optional feature): go DONE.
  - Cycles without sclk_edge: hold all state.
- DONE (exactly 1 clk):
  - rx_data ← received word; rx_valid=1; cs_n=1; mosi=0.
  - Next state IDLE, tx_ready=1 the following cycle.
- Latency: accept → rx_valid = FRAME sclk_edge pulses + 1 clk. No back-to-back acceptance; minimum 1 IDLE cycle between frames.
- Boundary conditions:
  - sclk_edge in the accept cycle is ignored (not counted); the first counted edge is the one after cs_n falls.
  - sclk_edge during DONE or IDLE is ignored.
  - tx_valid while busy: not accepted; host must hold tx_valid/tx_data until tx_ready.
  - tx_data changing after acceptance has no effect on the frame.
  - rst_n low mid-frame: immediate abort, all outputs to reset values, no rx_valid, partial rx data discarded.
  - rx_valid is never asserted for more than 1 clk; rx_data is stable outside DONE.

Optional Feature:
- Macro SERIAL_PARITY_EN.
- Defined:
  - FRAME=WIDTH+1. After the data bits, mosi drives even parity (XOR of the latched tx word) for one extra edge.
  - The miso bit sampled on that edge is compared with the XOR of the received data.
  - rx_parity_err=1 during DONE on mismatch, else 0. The parity bit is not placed in rx_data.
- Undefined: FRAME=WIDTH; rx_parity_err tied 0; port list unchanged.

Test Plan:
- Reset then idle → tx_ready=1, cs_n=1, mosi=0, rx_data=0, rx_valid=0.
- WIDTH=8, tx_data=0xA5, miso looped to mosi, sclk_edge every 64 clk → mosi sequence 1,0,1,0,0,1,0,1 across edges. After the 8th edge, rx_valid for 1 clk, rx_data=0xA5, cs_n rising that cycle.
- miso driven 0x3C MSB-first while sending 0xFF → rx_data=0x3C. tx_valid held during the frame with a new word → not accepted until tx_ready returns.
- sclk_edge asserted in the accept cycle and during DONE → frame still uses exactly 8 counted edges; rx_data correct.
- rst_n pulsed low after the 3rd edge → cs_n=1, tx_ready=1, no rx_valid. A following 0x5A frame completes correctly.
- SERIAL_PARITY_EN with loopback of 0x07 → 9th mosi bit=1, rx_parity_err=0. Forcing the 9th miso bit to 0 → rx_parity_err=1 with rx_valid.

Source files
------------

// File: rtl/serial_shift_engine.sv
// Serial shift engine: frames a parallel word with cs_n, shifts it MSB-first on sclk_edge pulses
// and returns the sampled miso word. Optional even-parity bit enabled by `define SERIAL_PARITY_EN.
module serial_shift_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_edge,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_parity_err,
    output logic             busy
);

`ifdef SERIAL_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [FRAME-1:0]   tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0]   rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               last_edge;

`ifdef SERIAL_PARITY_EN
    logic               perr_q, perr_d;
`endif

    assign last_edge = (bit_cnt_q == CNT_W'(FRAME - 1));

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_PARITY_EN
        perr_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
`ifdef SERIAL_PARITY_EN
                    // Parity rides in the LSB so it reaches the MSB after the data bits.
                    tx_sr_d = {tx_data, ^tx_data};
`else
                    tx_sr_d = tx_data;
`endif
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (sclk_edge) begin
                    tx_sr_d   = {tx_sr_q[FRAME-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef SERIAL_PARITY_EN
                    if (bit_cnt_q < CNT_W'(WIDTH)) begin
                        rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
                    end
`else
                    rx_sr_d = {rx_sr_q[WIDTH-2:0], miso};
`endif
                    if (last_edge) begin
                        state_d   = StDone;
                        rx_data_d = rx_sr_d;
`ifdef SERIAL_PARITY_EN
                        perr_d    = miso ^ (^rx_sr_q);
`endif
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign tx_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign cs_n     = (state_q != StShift);
    assign mosi     = (state_q == StShift) & tx_sr_q[FRAME-1];
    assign rx_valid = (state_q == StDone);
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_serial_shift_engine.sv
// Directed self-checking bench for serial_shift_engine (WIDTH=8); covers the parity build when
// SERIAL_PARITY_EN is defined.
module tb_serial_shift_engine;

`ifdef SERIAL_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic       sclk_edge;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       mosi;
    logic       miso;
    logic       cs_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    serial_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sclk_edge     (sclk_edge),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .mosi          (mosi),
        .miso          (miso),
        .cs_n          (cs_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only. Called at #1 after a posedge in IDLE; returns #1 after the accept edge.
    task automatic accept(input logic [7:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Stimulus only: FRAME sclk_edge pulses spaced gap clocks apart, records mosi before each.
    task automatic shift_bits(input logic [7:0] mw, input bit loop, input bit par_force,
                              input logic par_bit, input int gap, input bit hold_last,
                              output logic [FRAME-1:0] seen);
        seen = '0;
        for (int i = 0; i < FRAME; i++) begin
            repeat (gap - 1) begin
                @(posedge clk);
                #1;
            end
            seen[FRAME-1-i] = mosi;
            if (par_force && i == FRAME - 1) miso = par_bit;
            else if (loop)                   miso = mosi;
            else if (i < 8)                  miso = mw[7-i];
            else                             miso = par_bit;
            sclk_edge = 1'b1;
            @(posedge clk);
            #1;
            if (!(hold_last && i == FRAME - 1)) sclk_edge = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk_edge = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; miso = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b exp=1", cs_n); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", rx_parity_err); end
    endtask

    task automatic test_loopback();
        logic [FRAME-1:0] seen;
        logic [FRAME-1:0] exp_seq;
`ifdef SERIAL_PARITY_EN
        exp_seq = {8'hA5, 1'b0};
`else
        exp_seq = 8'hA5;
`endif
        accept(8'hA5);
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL lb_cs_low got=%b exp=0", cs_n); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL lb_tx_ready got=%b exp=0", tx_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lb_busy got=%b exp=1", busy); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL lb_first_mosi got=%b exp=1", mosi); end
        shift_bits(8'h00, 1'b1, 1'b0, 1'b0, 64, 1'b0, seen);
        checks++; if (seen !== exp_seq) begin errors++; $display("FAIL lb_mosi_seq got=%h exp=%h", seen, exp_seq); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL lb_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL lb_rx_data got=%h exp=a5", rx_data); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL lb_cs_done got=%b exp=1", cs_n); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL lb_mosi_done got=%b exp=0", mosi); end
        checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL lb_perr got=%b exp=0", rx_parity_err); end
        @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL lb_rx_valid_pulse got=%b exp=0", rx_valid); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL lb_tx_ready_after got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL lb_rx_data_hold got=%h exp=a5", rx_data); end
    endtask

    task automatic test_miso_capture();
        logic [FRAME-1:0] seen;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h81;  // host already presenting the next word, tx_valid kept high
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL cap_tx_ready got=%b exp=0", tx_ready); end
        shift_bits(8'h3C, 1'b0, 1'b0, 1'b0, 4, 1'b0, seen);
        checks++; if (seen[FRAME-1 -: 8] !== 8'hFF) begin errors++; $display("FAIL cap_mosi got=%h exp=ff", seen[FRAME-1 -: 8]); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL cap_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL cap_rx_data got=%h exp=3c", rx_data); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL cap_no_b2b got=%b exp=0", tx_ready); end
        @(posedge clk);
        #1;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL cap_idle_ready got=%b exp=1", tx_ready); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL cap_idle_cs got=%b exp=1", cs_n); end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        checks++; if (cs_n !== 1'b0) begin errors++; $display("FAIL cap_second_cs got=%b exp=0", cs_n); end
        shift_bits(8'h00, 1'b1, 1'b0, 1'b0, 3, 1'b0, seen);
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL cap_second_rx got=%h exp=81", rx_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignored_edges();
        logic [FRAME-1:0] seen;
        tx_data   = 8'h96;
        tx_valid  = 1'b1;
        sclk_edge = 1'b1;
        @(posedge clk);
        #1;
        tx_valid  = 1'b0;
        sclk_edge = 1'b0;
        checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL ign_first_mosi got=%b exp=1", mosi); end
        shift_bits(8'h00, 1'b1, 1'b0, 1'b0, 4, 1'b1, seen);
        checks++; if (seen[FRAME-1 -: 8] !== 8'h96) begin errors++; $display("FAIL ign_mosi got=%h exp=96", seen[FRAME-1 -: 8]); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ign_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("FAIL ign_rx_data got=%h exp=96", rx_data); end
        @(posedge clk);
        #1;
        sclk_edge = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ign_rx_valid_after got=%b exp=0", rx_valid); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL ign_cs_after got=%b exp=1", cs_n); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL ign_ready_after got=%b exp=1", tx_ready); end
    endtask

    task automatic test_reset_abort();
        logic [FRAME-1:0] seen;
        accept(8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            miso      = 1'b1;
            sclk_edge = 1'b1;
            @(posedge clk);
            #1;
            sclk_edge = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL abort_cs got=%b exp=1", cs_n); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL abort_mosi got=%b exp=0", mosi); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL abort_rx_data got=%h exp=00", rx_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid got=%b exp=0", rx_valid); end
        accept(8'h5A);
        shift_bits(8'h00, 1'b1, 1'b0, 1'b0, 4, 1'b0, seen);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL post_rx_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL post_rx_data got=%h exp=5a", rx_data); end
        @(posedge clk);
        #1;
    endtask

`ifdef SERIAL_PARITY_EN
    task automatic test_parity();
        logic [FRAME-1:0] seen;
        accept(8'h07);
        shift_bits(8'h00, 1'b1, 1'b0, 1'b0, 4, 1'b0, seen);
        checks++; if (seen[0] !== 1'b1) begin errors++; $display("FAIL par_bit got=%b exp=1", seen[0]); end
        checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL par_ok got=%b exp=0", rx_parity_err); end
        checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL par_rx_data got=%h exp=07", rx_data); end
        @(posedge clk);
        #1;
        accept(8'h07);
        shift_bits(8'h00, 1'b1, 1'b1, 1'b0, 4, 1'b0, seen);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL par_err_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_parity_err !== 1'b1) begin errors++; $display("FAIL par_err got=%b exp=1", rx_parity_err); end
        @(posedge clk);
        #1;
        checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL par_err_clear got=%b exp=0", rx_parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_miso_capture();
        test_ignored_edges();
        test_reset_abort();
`ifdef SERIAL_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
